terminal_arbiter: RTL and testbench

- Shares the single text-RAM port of the VGA text terminal between two requesters: the CPU console path (port 0) and the debugger register-dump path (port 1).
- Round-robin arbitration; exactly one access per clock.
- Contains a clear-screen sequencer that fills every text cell with a fill character.
- Runs on the 25 MHz clock domain and sits between the requesters and the terminal text port.

---
 rtl/terminal_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/terminal_arbiter.sv | 144 ++++++++++++++
 tb/tb_terminal_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/terminal_pkg.sv
// Shared constants, state type and port indices for the VGA text-terminal access path.
package terminal_pkg;

  localparam int unsigned TERM_ADDR_WIDTH = 12;
  localparam int unsigned TERM_DATA_WIDTH = 8;
  localparam int unsigned TERM_COLS       = 80;
  localparam int unsigned TERM_ROWS       = 30;
  localparam logic [TERM_DATA_WIDTH-1:0] TERM_FILL_CHAR = 8'h20;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DBG = 1;

  typedef enum logic [0:0] {
    StServe,
    StClear
  } term_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the other port after a grant.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // prio_q == 0 favours port 0 when both request
  logic prio_q, prio_d;

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || !prio_q)) begin
        gnt_o = 2'b01;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
      end
    end
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/terminal_arbiter.sv
// Shares the terminal text-RAM port between CPU console and debugger, with a clear-screen sequencer.
// Define CLEAR_ON_RESET_EN to blank the screen automatically when leaving reset.
module terminal_arbiter
  import terminal_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = TERM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = TERM_DATA_WIDTH,
  parameter int unsigned TEXT_CELLS = TERM_COLS * TERM_ROWS,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR = TERM_FILL_CHAR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_grant,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_grant,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clear_start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] text_addr,
  output logic                  text_write,
  output logic [DATA_WIDTH-1:0] text_wdata,
  input  logic [DATA_WIDTH-1:0] text_rdata
);

`ifdef CLEAR_ON_RESET_EN
  localparam term_state_e ResetState = StClear;
`else
  localparam term_state_e ResetState = StServe;
`endif

  localparam logic [ADDR_WIDTH-1:0] LastCell = ADDR_WIDTH'(TEXT_CELLS - 1);

  term_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
  logic [ADDR_WIDTH-1:0] text_addr_q, text_addr_d;
  logic                  text_write_q, text_write_d;
  logic [DATA_WIDTH-1:0] text_wdata_q, text_wdata_d;
  logic [1:0]            gnt;
  logic                  issue_rd;
  logic                  issue_port;
  // Stage 0 tracks reads whose address is on the bus, stage 1 those whose data is returning
  logic [1:0]            tag_vld_q;
  logic [1:0]            tag_port_q;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Held off during reset so a requester never sees an access that the reset then discards
  rr_arbiter2 u_rr_arbiter2 (
    .clk_i (clock),
    .rst_i (reset),
    .en_i  ((state_q == StServe) && !reset),
    .req_i ({p1_req, p0_req}),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    text_addr_d  = text_addr_q;
    text_write_d = 1'b0;
    text_wdata_d = text_wdata_q;
    issue_rd     = 1'b0;
    issue_port   = 1'b0;
    case (state_q)
      StServe: begin
        if (gnt[0]) begin
          text_addr_d  = p0_addr;
          text_write_d = p0_write;
          text_wdata_d = p0_wdata;
          issue_rd     = !p0_write;
          issue_port   = 1'(PORT_CPU);
        end else if (gnt[1]) begin
          text_addr_d  = p1_addr;
          text_write_d = p1_write;
          text_wdata_d = p1_wdata;
          issue_rd     = !p1_write;
          issue_port   = 1'(PORT_DBG);
        end
        if (clear_start) begin
          state_d = StClear;
        end
      end
      StClear: begin
        text_addr_d  = clear_ptr_q;
        text_write_d = 1'b1;
        text_wdata_d = FILL_CHAR;
        if (clear_ptr_q == LastCell) begin
          state_d     = StServe;
          clear_ptr_d = '0;
        end else begin
          clear_ptr_d = clear_ptr_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ResetState;
      clear_ptr_q  <= '0;
      text_addr_q  <= '0;
      text_write_q <= 1'b0;
      text_wdata_q <= '0;
      tag_vld_q    <= '0;
      tag_port_q   <= '0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      text_addr_q  <= text_addr_d;
      text_write_q <= text_write_d;
      text_wdata_q <= text_wdata_d;
      tag_vld_q    <= {tag_vld_q[0], issue_rd};
      tag_port_q   <= {tag_port_q[0], issue_port};
      p0_rvalid_q  <= tag_vld_q[1] && (tag_port_q[1] == 1'(PORT_CPU));
      p1_rvalid_q  <= tag_vld_q[1] && (tag_port_q[1] == 1'(PORT_DBG));
      if (tag_vld_q[1]) begin
        rdata_q <= text_rdata;
      end
    end
  end

  assign p0_grant   = gnt[0];
  assign p1_grant   = gnt[1];
  assign p0_rvalid  = p0_rvalid_q;
  assign p1_rvalid  = p1_rvalid_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q == StClear);
  assign text_addr  = text_addr_q;
  assign text_write = text_write_q;
  assign text_wdata = text_wdata_q;

endmodule

// File: tb/tb_terminal_arbiter.sv
// Self-checking bench for terminal_arbiter: transaction-level model plus directed literal checks.
module tb_terminal_arbiter;

  logic        clock;
  logic        reset;
  logic        p0_req, p0_write, p0_grant, p0_rvalid;
  logic [11:0] p0_addr;
  logic [7:0]  p0_wdata;
  logic        p1_req, p1_write, p1_grant, p1_rvalid;
  logic [11:0] p1_addr;
  logic [7:0]  p1_wdata;
  logic [7:0]  rdata;
  logic        clear_start, busy;
  logic [11:0] text_addr;
  logic        text_write;
  logic [7:0]  text_wdata;
  logic [7:0]  text_rdata;

  terminal_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .p0_req      (p0_req),
    .p0_write    (p0_write),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_grant    (p0_grant),
    .p0_rvalid   (p0_rvalid),
    .p1_req      (p1_req),
    .p1_write    (p1_write),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_grant    (p1_grant),
    .p1_rvalid   (p1_rvalid),
    .rdata       (rdata),
    .clear_start (clear_start),
    .busy        (busy),
    .text_addr   (text_addr),
    .text_write  (text_write),
    .text_wdata  (text_wdata),
    .text_rdata  (text_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Terminal text RAM with one-cycle read latency
  logic [7:0] ram [4096];
  always @(posedge clock) begin
    if (text_write) ram[text_addr] <= text_wdata;
    text_rdata <= ram[text_addr];
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference: screen contents as seen by accesses in issue order, plus pending read results
  logic [7:0]  mmem [4096];
  int          m_fav;
  bit          m_clr;
  int          m_ptr;
  bit          e_tw;
  logic [11:0] e_addr;
  logic [7:0]  e_wdata;
  bit          pv [8];
  int          pp [8];
  logic [7:0]  pd [8];

  logic        d_reset, d_clear;
  logic        d_p0_req, d_p0_write, d_p1_req, d_p1_write;
  logic [11:0] d_p0_addr, d_p1_addr;
  logic [7:0]  d_p0_wdata, d_p1_wdata;

  logic        s_busy, s_tw, s_rv0, s_rv1, s_g0, s_g1;
  logic [11:0] s_addr;
  logic [7:0]  s_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic cycle();
    int k;
    int g;
    int kn;
    k = cyc % 8;
    @(negedge clock);
    s_busy  = busy;
    s_tw    = text_write;
    s_addr  = text_addr;
    s_rv0   = p0_rvalid;
    s_rv1   = p1_rvalid;
    s_rdata = rdata;
    if (chk_en) begin
      check("busy", busy, m_clr);
      check("text_write", text_write, e_tw);
      check("text_addr", text_addr, e_addr);
      if (e_tw) check("text_wdata", text_wdata, e_wdata);
      check("p0_rvalid", p0_rvalid, pv[k] && pp[k] == 0);
      check("p1_rvalid", p1_rvalid, pv[k] && pp[k] == 1);
      if (pv[k]) check("rdata", rdata, pd[k]);
    end
    pv[k] = 0;
    reset       = d_reset;
    clear_start = d_clear;
    p0_req = d_p0_req; p0_write = d_p0_write; p0_addr = d_p0_addr; p0_wdata = d_p0_wdata;
    p1_req = d_p1_req; p1_write = d_p1_write; p1_addr = d_p1_addr; p1_wdata = d_p1_wdata;
    #1;
    g = -1;
    if (!d_reset && !m_clr) begin
      if (d_p0_req && (!d_p1_req || m_fav == 0)) g = 0;
      else if (d_p1_req) g = 1;
    end
    s_g0 = p0_grant;
    s_g1 = p1_grant;
    if (chk_en) begin
      check("p0_grant", p0_grant, g == 0);
      check("p1_grant", p1_grant, g == 1);
    end
    kn = (cyc + 3) % 8;
    if (d_reset) begin
      m_fav = 0; m_clr = 0; m_ptr = 0;
      e_tw = 0; e_addr = '0; e_wdata = '0;
      for (int i = 0; i < 8; i++) pv[i] = 0;
    end else if (m_clr) begin
      e_tw = 1; e_addr = 12'(m_ptr); e_wdata = 8'h20;
      mmem[m_ptr] = 8'h20;
      if (m_ptr == 2399) begin
        m_clr = 0; m_ptr = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      if (g >= 0) begin
        e_tw    = (g == 0) ? d_p0_write : d_p1_write;
        e_addr  = (g == 0) ? d_p0_addr  : d_p1_addr;
        e_wdata = (g == 0) ? d_p0_wdata : d_p1_wdata;
        m_fav   = 1 - g;
        if (e_tw) begin
          mmem[e_addr] = e_wdata;
        end else begin
          pv[kn] = 1; pp[kn] = g; pd[kn] = mmem[e_addr];
        end
      end else begin
        e_tw = 0;
      end
      if (d_clear) m_clr = 1;
    end
    cyc++;
  endtask

  task automatic new_req(input int p);
    logic [11:0] a;
    a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
    if (p == 0) begin
      d_p0_req = ($urandom_range(0, 2) != 0); d_p0_write = $urandom_range(0, 1) == 1;
      d_p0_addr = a; d_p0_wdata = 8'($urandom);
    end else begin
      d_p1_req = ($urandom_range(0, 2) != 0); d_p1_write = $urandom_range(0, 1) == 1;
      d_p1_addr = a; d_p1_wdata = 8'($urandom);
    end
  endtask

  initial begin
    int  cnt;
    bit  done;
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 8'($urandom);
      mmem[i] = ram[i];
    end
    ram[5] = 8'h41; mmem[5] = 8'h41;
    m_fav = 0; m_clr = 0; m_ptr = 0; e_tw = 0; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < 8; i++) begin pv[i] = 0; pp[i] = 0; pd[i] = '0; end
    d_reset = 1; d_clear = 0;
    d_p0_req = 0; d_p0_write = 0; d_p0_addr = '0; d_p0_wdata = '0;
    d_p1_req = 0; d_p1_write = 0; d_p1_addr = '0; d_p1_wdata = '0;

    // Reset state
    cycle();
    chk_en = 1;
    cycle();
    cycle();
    d_reset = 0;
    cycle();
    check("rst_busy", s_busy, 0);
    check("rst_text_write", s_tw, 0);
    check("rst_text_addr", s_addr, 0);
    check("rst_rvalid", {s_rv1, s_rv0}, 0);
    check("rst_rdata", s_rdata, 0);

    // Both requesting writes: strict alternation starting at port 0
    d_p0_req = 1; d_p1_req = 1; d_p0_write = 1; d_p1_write = 1;
    for (int i = 0; i < 4; i++) begin
      d_p0_addr = 12'(100 + i); d_p1_addr = 12'(200 + i);
      d_p0_wdata = 8'(i); d_p1_wdata = 8'(16 + i);
      cycle();
      check("alt_p0_grant", s_g0, (i % 2) == 0);
      check("alt_p1_grant", s_g1, (i % 2) == 1);
    end
    d_p0_req = 0; d_p1_req = 0;
    cycle();
    check("alt_last_addr", s_addr, 12'd203);

    // Debugger read of cell 5 (holds 8'h41)
    d_p1_req = 1; d_p1_write = 0; d_p1_addr = 12'h005;
    cycle();
    check("rd_grant", s_g1, 1);
    d_p1_req = 0;
    cycle();
    cycle();
    check("rd_t2_rvalid", s_rv1, 0);
    cycle();
    check("rd_t3_rvalid", s_rv1, 1);
    check("rd_t3_rdata", s_rdata, 8'h41);
    check("rd_t3_p0_rvalid", s_rv0, 0);
    cycle();
    check("rd_t4_rvalid", s_rv1, 0);

    // Out-of-range address passes straight through
    d_p0_req = 1; d_p0_write = 1; d_p0_addr = 12'hFFF; d_p0_wdata = 8'h5A;
    cycle();
    d_p0_req = 0;
    cycle();
    check("fff_addr", s_addr, 12'hFFF);
    check("fff_write", s_tw, 1);

    // Clear with a read issued alongside the start pulse, a held CPU write, restart attempt at 1000
    d_clear = 1; d_p1_req = 1; d_p1_write = 0; d_p1_addr = 12'h005;
    cycle();
    check("clr_start_grant", s_g1, 1);
    d_clear = 0; d_p1_req = 0;
    d_p0_req = 1; d_p0_write = 1; d_p0_addr = 12'h007; d_p0_wdata = 8'h33;
    cnt = 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      d_clear = m_clr && (m_ptr == 1000);
      cycle();
      if (s_busy) cnt++;
      else begin
        done = 1;
        check("post_clear_grant", s_g0, 1);
      end
    end
    check("clear_done", done, 1);
    check("busy_len", cnt, 2400);
    d_p0_req = 0; d_clear = 0;
    cycle();
    check("post_clear_addr", s_addr, 12'h007);

    // Reset with a read in flight, just after a clear begins
    d_clear = 1; d_p0_req = 1; d_p0_write = 0; d_p0_addr = 12'h009;
    cycle();
    d_clear = 0; d_p0_req = 0;
    cycle();
    d_reset = 1;
    cycle();
    d_reset = 0;
    cycle();
    check("rst_rd_busy", s_busy, 0);
    check("rst_rd_write", s_tw, 0);
    check("rst_rd_rvalid", s_rv0, 0);

    // Reset at clear_ptr 500
    d_clear = 1;
    cycle();
    d_clear = 0;
    for (int i = 0; i < 600 && m_ptr != 500; i++) cycle();
    d_reset = 1;
    cycle();
    d_reset = 0;
    cycle();
    check("rst500_busy", s_busy, 0);
    check("rst500_write", s_tw, 0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 7000; i++) begin
      if (!d_p0_req || s_g0) new_req(0);
      if (!d_p1_req || s_g1) new_req(1);
      d_clear = ($urandom_range(0, 1999) == 0);
      d_reset = ($urandom_range(0, 899) == 0);
      cycle();
    end
    d_p0_req = 0; d_p1_req = 0; d_clear = 0; d_reset = 0;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
